// File: rtl/pe_weight_replay_buf.sv
// Weight group buffer: holds group_len words and replays them replay times before freeing storage.
// With replay=1 it degenerates to a first-word-fall-through FIFO.
module pe_weight_replay_buf #(
    parameter int DATA_WIDTH   = 8,
    parameter int Wh           = 2,
    parameter int Ww           = 29,
    parameter int DEPTH        = 136,
    parameter int DEF_GROUP    = 1,
    parameter int REPLAY_WIDTH = 8,
    parameter int CW           = $clog2(DEPTH + 1)
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   cfg_load,
    input  logic [CW-1:0]                          cfg_group_len,
    input  logic [REPLAY_WIDTH-1:0]                cfg_replay,
    input  logic                                   wr_en,
    input  logic [Wh-1:0][Ww-1:0][DATA_WIDTH-1:0]  din,
    output logic                                   full,
    output logic [CW-1:0]                          occ,
    input  logic                                   rd_en,
    output logic [Wh-1:0][Ww-1:0][DATA_WIDTH-1:0]  dout,
    output logic                                   valid,
    output logic [REPLAY_WIDTH-1:0]                pass_idx,
    output logic                                   group_done,
    output logic                                   overflow_err,
    output logic                                   underflow_err,
    output logic                                   cfg_err
);

    localparam int IW = $clog2(DEPTH);
    localparam int SW = CW + 1;
    localparam int RW = REPLAY_WIDTH;

    logic [Wh-1:0][Ww-1:0][DATA_WIDTH-1:0] mem [DEPTH];

    logic [IW-1:0] wrIdx_q, wrIdx_d;
    logic [IW-1:0] baseIdx_q, baseIdx_d;
    logic [CW-1:0] rdOff_q, rdOff_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [RW-1:0] passIdx_q, passIdx_d;
    logic [CW-1:0] groupLen_q, groupLen_d;
    logic [RW-1:0] replay_q, replay_d;
    logic          groupDone_q, groupDone_d;
    logic          overflowErr_q, overflowErr_d;
    logic          underflowErr_q, underflowErr_d;
    logic          cfgErr_q, cfgErr_d;

    logic          wrAcc, rdAcc, relAcc, lastOff, lastPass, cfgAcc, cfgOk;
    logic [SW-1:0] rdSum, relSum;
    logic [IW-1:0] rdAddr;

    assign full  = (occ_q == CW'(DEPTH));
    assign valid = (rdOff_q < occ_q);

    // base + offset is below 2*DEPTH, so a single conditional subtract wraps it
    assign rdSum  = SW'(baseIdx_q) + SW'(rdOff_q);
    assign relSum = SW'(baseIdx_q) + SW'(groupLen_q);
    assign rdAddr = (rdSum >= SW'(DEPTH)) ? IW'(rdSum - SW'(DEPTH)) : IW'(rdSum);
    assign dout   = mem[rdAddr];

    always_comb begin
        wrAcc    = wr_en && !full;
        rdAcc    = rd_en && valid;
        lastOff  = (rdOff_q == groupLen_q - CW'(1));
        lastPass = (passIdx_q == replay_q - RW'(1));
        relAcc   = rdAcc && lastOff && lastPass;
        cfgAcc   = cfg_load && (occ_q == '0);
        cfgOk    = (cfg_group_len != '0) && (cfg_group_len <= CW'(DEPTH));

        wrIdx_d        = wrIdx_q;
        baseIdx_d      = baseIdx_q;
        rdOff_d        = rdOff_q;
        passIdx_d      = passIdx_q;
        groupLen_d     = groupLen_q;
        replay_d       = replay_q;
        overflowErr_d  = overflowErr_q;
        underflowErr_d = underflowErr_q;
        cfgErr_d       = cfgErr_q;
        groupDone_d    = relAcc;
        occ_d          = occ_q + (wrAcc ? CW'(1) : CW'(0)) - (relAcc ? groupLen_q : CW'(0));

        if (wrAcc)
            wrIdx_d = (wrIdx_q == IW'(DEPTH - 1)) ? '0 : wrIdx_q + IW'(1);

        if (rdAcc) begin
            if (!lastOff) begin
                rdOff_d = rdOff_q + CW'(1);
            end else if (!lastPass) begin
                rdOff_d   = '0;
                passIdx_d = passIdx_q + RW'(1);
            end else begin
                rdOff_d   = '0;
                passIdx_d = '0;
                baseIdx_d = (relSum >= SW'(DEPTH)) ? IW'(relSum - SW'(DEPTH)) : IW'(relSum);
            end
        end

        // A good load clears the sticky flags; a fresh error in that same cycle still lands
        if (cfgAcc && cfgOk) begin
            groupLen_d     = cfg_group_len;
            replay_d       = (cfg_replay == '0) ? RW'(1) : cfg_replay;
            overflowErr_d  = 1'b0;
            underflowErr_d = 1'b0;
            cfgErr_d       = 1'b0;
        end else if (cfgAcc) begin
            cfgErr_d = 1'b1;
        end

        if (wr_en && full)
            overflowErr_d = 1'b1;
        if (rd_en && !valid)
            underflowErr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrIdx_q        <= '0;
            baseIdx_q      <= '0;
            rdOff_q        <= '0;
            occ_q          <= '0;
            passIdx_q      <= '0;
            groupLen_q     <= CW'(DEF_GROUP);
            replay_q       <= RW'(1);
            groupDone_q    <= 1'b0;
            overflowErr_q  <= 1'b0;
            underflowErr_q <= 1'b0;
            cfgErr_q       <= 1'b0;
        end else begin
            wrIdx_q        <= wrIdx_d;
            baseIdx_q      <= baseIdx_d;
            rdOff_q        <= rdOff_d;
            occ_q          <= occ_d;
            passIdx_q      <= passIdx_d;
            groupLen_q     <= groupLen_d;
            replay_q       <= replay_d;
            groupDone_q    <= groupDone_d;
            overflowErr_q  <= overflowErr_d;
            underflowErr_q <= underflowErr_d;
            cfgErr_q       <= cfgErr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wrAcc)
            mem[wrIdx_q] <= din;
    end

    assign occ           = occ_q;
    assign pass_idx      = passIdx_q;
    assign group_done    = groupDone_q;
    assign overflow_err  = overflowErr_q;
    assign underflow_err = underflowErr_q;
    assign cfg_err       = cfgErr_q;

endmodule

// File: tb/tb_pe_weight_replay_buf.sv
// Scoreboard bench for pe_weight_replay_buf with an 8-entry buffer; inputs change and
// outputs are sampled on the falling clock edge.
module tb_pe_weight_replay_buf;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int WH    = 2;
    localparam int WW    = 29;
    localparam int RW    = 8;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int WORDW = WH * WW * DW;

    typedef struct packed {
        logic [WORDW-1:0] w;
        logic [RW-1:0]    p;
        logic             rel;
    } expT;

    logic                          clk;
    logic                          rstn;
    logic                          cfg_load;
    logic [CW-1:0]                 cfg_group_len;
    logic [RW-1:0]                 cfg_replay;
    logic                          wr_en;
    logic [WH-1:0][WW-1:0][DW-1:0] din;
    logic                          full;
    logic [CW-1:0]                 occ;
    logic                          rd_en;
    logic [WH-1:0][WW-1:0][DW-1:0] dout;
    logic                          valid;
    logic [RW-1:0]                 pass_idx;
    logic                          group_done;
    logic                          overflow_err;
    logic                          underflow_err;
    logic                          cfg_err;

    int  total = 0;
    int  bad = 0;
    int  modelOcc = 0;
    int  curL = 1;
    expT expQ[$];

    pe_weight_replay_buf #(
        .DATA_WIDTH(DW), .Wh(WH), .Ww(WW), .DEPTH(DEPTH), .DEF_GROUP(1), .REPLAY_WIDTH(RW)
    ) dut (
        .clk(clk), .rstn(rstn), .cfg_load(cfg_load), .cfg_group_len(cfg_group_len),
        .cfg_replay(cfg_replay), .wr_en(wr_en), .din(din), .full(full), .occ(occ),
        .rd_en(rd_en), .dout(dout), .valid(valid), .pass_idx(pass_idx),
        .group_done(group_done), .overflow_err(overflow_err),
        .underflow_err(underflow_err), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [WORDW-1:0] mkWord(input int n);
        logic [15:0] h;
        h = 16'(n) ^ 16'hA5C3;
        return {29{h}};
    endfunction

    task automatic checkOutput(input string tag, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic configure(input int len, input int rep, input bit accept);
        cfg_load      = 1'b1;
        cfg_group_len = CW'(len);
        cfg_replay    = RW'(rep);
        @(negedge clk);
        cfg_load = 1'b0;
        if (accept)
            curL = len;
    endtask

    task automatic applyStimulus(input int n);
        wr_en = 1'b1;
        din   = mkWord(n);
        @(negedge clk);
        wr_en = 1'b0;
        if (modelOcc < DEPTH)
            modelOcc++;
    endtask

    task automatic pushExp(input int n, input int p, input bit rel);
        expT e;
        e.w   = mkWord(n);
        e.p   = RW'(p);
        e.rel = rel;
        expQ.push_back(e);
    endtask

    task automatic readAndCheck(input int count);
        expT e;
        for (int i = 0; i < count; i++) begin
            e = expQ.pop_front();
            checkOutput("valid", 512'(valid), 512'(1));
            checkOutput("dout", 512'(dout), 512'(e.w));
            checkOutput("pass_idx", 512'(pass_idx), 512'(e.p));
            checkOutput("occ", 512'(occ), 512'(modelOcc));
            checkOutput("full", 512'(full), 512'(modelOcc == DEPTH));
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            if (e.rel)
                modelOcc -= curL;
            checkOutput("group_done", 512'(group_done), 512'(e.rel));
        end
    endtask

    initial begin
        rstn = 1'b0; cfg_load = 1'b0; cfg_group_len = '0; cfg_replay = '0;
        wr_en = 1'b0; din = '0; rd_en = 1'b0;
        #3;
        checkOutput("rst_valid", 512'(valid), 512'(0));
        checkOutput("rst_full", 512'(full), 512'(0));
        checkOutput("rst_occ", 512'(occ), 512'(0));
        checkOutput("rst_pass", 512'(pass_idx), 512'(0));
        checkOutput("rst_done", 512'(group_done), 512'(0));
        checkOutput("rst_errs", 512'({overflow_err, underflow_err, cfg_err}), 512'(0));
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Plain FIFO behaviour with wrap-around of both indices
        configure(4, 1, 1);
        for (int n = 0; n < 8; n++) applyStimulus(n);
        checkOutput("t1_full", 512'(full), 512'(1));
        for (int n = 0; n < 12; n++) pushExp(n, 0, (n % 4) == 3);
        readAndCheck(4);
        applyStimulus(8);
        applyStimulus(9);
        readAndCheck(6);
        checkOutput("t1_partial_valid", 512'(valid), 512'(0));
        applyStimulus(10);
        applyStimulus(11);
        readAndCheck(2);

        // Two-pass replay of a 3-word group, with a partial second group
        configure(3, 2, 1);
        for (int n = 100; n < 104; n++) applyStimulus(n);
        pushExp(100, 0, 0); pushExp(101, 0, 0); pushExp(102, 0, 0);
        pushExp(100, 1, 0); pushExp(101, 1, 0); pushExp(102, 1, 1);
        pushExp(103, 0, 0);
        readAndCheck(7);
        checkOutput("t2_occ_after", 512'(occ), 512'(1));
        checkOutput("t2_stall_valid", 512'(valid), 512'(0));
        applyStimulus(104);
        applyStimulus(105);
        pushExp(104, 0, 0); pushExp(105, 0, 0);
        pushExp(103, 1, 0); pushExp(104, 1, 0); pushExp(105, 1, 1);
        readAndCheck(5);

        // Whole-buffer group: full holds through both passes, extra write dropped
        configure(DEPTH, 2, 1);
        for (int n = 200; n < 209; n++) applyStimulus(n);
        checkOutput("t3_overflow", 512'(overflow_err), 512'(1));
        checkOutput("t3_full", 512'(full), 512'(1));
        for (int n = 200; n < 208; n++) pushExp(n, 0, 0);
        for (int n = 200; n < 208; n++) pushExp(n, 1, n == 207);
        readAndCheck(16);
        checkOutput("t3_full_after", 512'(full), 512'(0));
        checkOutput("t3_occ_after", 512'(occ), 512'(0));

        // Underflow on empty, then a good config load clears every sticky flag
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checkOutput("t4_underflow", 512'(underflow_err), 512'(1));
        checkOutput("t4_valid", 512'(valid), 512'(0));
        checkOutput("t4_occ", 512'(occ), 512'(0));
        checkOutput("t4_pass", 512'(pass_idx), 512'(0));
        configure(2, 1, 1);
        checkOutput("t4_underflow_clr", 512'(underflow_err), 512'(0));
        checkOutput("t4_overflow_clr", 512'(overflow_err), 512'(0));

        // Config loads: ignored when not empty, rejected when out of range
        applyStimulus(300);
        applyStimulus(301);
        configure(5, 1, 0);
        checkOutput("t5_ignored_err", 512'(cfg_err), 512'(0));
        pushExp(300, 0, 0); pushExp(301, 0, 1);
        readAndCheck(2);
        configure(0, 1, 0);
        checkOutput("t5_zero_err", 512'(cfg_err), 512'(1));
        applyStimulus(302);
        applyStimulus(303);
        pushExp(302, 0, 0); pushExp(303, 0, 1);
        readAndCheck(2);
        checkOutput("t5_err_sticky", 512'(cfg_err), 512'(1));
        configure(2, 1, 1);
        checkOutput("t5_err_clr", 512'(cfg_err), 512'(0));
        configure(DEPTH + 1, 1, 0);
        checkOutput("t5_big_err", 512'(cfg_err), 512'(1));
        configure(DEPTH, 0, 1);
        checkOutput("t5_depth_ok", 512'(cfg_err), 512'(0));
        for (int n = 400; n < 408; n++) applyStimulus(n);
        for (int n = 400; n < 408; n++) pushExp(n, 0, n == 407);
        readAndCheck(8);

        // Asynchronous reset in the middle of the second pass
        configure(2, 3, 1);
        applyStimulus(500);
        applyStimulus(501);
        pushExp(500, 0, 0); pushExp(501, 0, 0); pushExp(500, 1, 0);
        readAndCheck(3);
        checkOutput("t6_pass_before", 512'(pass_idx), 512'(1));
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 512'(valid), 512'(0));
        checkOutput("t6_rst_full", 512'(full), 512'(0));
        checkOutput("t6_rst_occ", 512'(occ), 512'(0));
        checkOutput("t6_rst_pass", 512'(pass_idx), 512'(0));
        @(negedge clk);
        rstn = 1'b1;
        modelOcc = 0;
        curL = 1;
        expQ.delete();
        for (int n = 600; n < 603; n++) applyStimulus(n);
        for (int n = 600; n < 603; n++) pushExp(n, 0, 1);
        readAndCheck(3);
        checkOutput("t6_final_occ", 512'(occ), 512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
